// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, credit-limited imem requests, in-order response buffering.
// Define IFU_MISALIGN_CHK_EN to add fetch_misalign and block fetch after a misaligned redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFU_MISALIGN_CHK_EN
    output logic        fetch_misalign,
`endif
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int unsigned IW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   pc_q;
    logic          epoch_q;
    logic          active_q;
    logic [OW-1:0] out_cnt_q;
    logic [TW-1:0] trk_wr_q;
    logic [TW-1:0] trk_rd_q;
    logic [31:0]   trk_pc_q    [MAX_OUTSTANDING];
    logic          trk_epoch_q [MAX_OUTSTANDING];
    logic [IW-1:0] buf_wr_q;
    logic [IW-1:0] buf_rd_q;
    logic [CW-1:0] buf_cnt_q;
    logic [31:0]   buf_data_q  [FIFO_DEPTH];
    logic [31:0]   buf_pc_q    [FIFO_DEPTH];

    logic        fetch_block;
    logic        issue;
    logic        rsp;
    logic        buf_push;
    logic        buf_pop;
    logic [31:0] credit_sum;
    logic [31:0] redirect_target;

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q;

    assign fetch_block     = misalign_q;
    assign fetch_misalign  = misalign_q;
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= |redirect_pc[1:0];
        end
    end
`else
    logic unused_redirect_lsb;

    assign fetch_block         = 1'b0;
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    function automatic logic [TW-1:0] trk_next(input logic [TW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
    endfunction

    // Credits cover in-flight requests too, so every response is guaranteed a buffer slot.
    assign credit_sum = 32'(out_cnt_q) + 32'(buf_cnt_q);
    assign imem_req   = active_q && !redirect_valid && !fetch_block
                        && (32'(out_cnt_q) < MAX_OUTSTANDING) && (credit_sum < FIFO_DEPTH);
    assign imem_addr  = pc_q;
    assign issue      = imem_req && imem_gnt;
    assign rsp        = imem_rvalid && (out_cnt_q != '0);
    assign buf_push   = rsp && !redirect_valid && (trk_epoch_q[trk_rd_q] == epoch_q);
    assign inst_valid = (buf_cnt_q != '0);
    assign buf_pop    = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? buf_data_q[buf_rd_q] : '0;
    assign inst_pc    = inst_valid ? buf_pc_q[buf_rd_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            epoch_q   <= 1'b0;
            active_q  <= 1'b0;
            out_cnt_q <= '0;
            trk_wr_q  <= '0;
            trk_rd_q  <= '0;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_cnt_q <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                trk_pc_q[i]    <= '0;
                trk_epoch_q[i] <= 1'b0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            active_q <= 1'b1;
            if (redirect_valid) begin
                pc_q    <= redirect_target;
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end

            if (issue) begin
                trk_pc_q[trk_wr_q]    <= pc_q;
                trk_epoch_q[trk_wr_q] <= epoch_q;
                trk_wr_q              <= trk_next(trk_wr_q);
            end
            if (rsp) begin
                trk_rd_q <= trk_next(trk_rd_q);
            end
            if (issue && !rsp) begin
                out_cnt_q <= out_cnt_q + OW'(1);
            end else if (!issue && rsp) begin
                out_cnt_q <= out_cnt_q - OW'(1);
            end

            if (redirect_valid) begin
                buf_wr_q  <= '0;
                buf_rd_q  <= '0;
                buf_cnt_q <= '0;
            end else begin
                if (buf_push) begin
                    buf_data_q[buf_wr_q] <= imem_rdata;
                    buf_pc_q[buf_wr_q]   <= trk_pc_q[trk_rd_q];
                    buf_wr_q             <= buf_wr_q + IW'(1);
                end
                if (buf_pop) begin
                    buf_rd_q <= buf_rd_q + IW'(1);
                end
                if (buf_push && !buf_pop) begin
                    buf_cnt_q <= buf_cnt_q + CW'(1);
                end else if (!buf_push && buf_pop) begin
                    buf_cnt_q <= buf_cnt_q - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: memory model, scoreboard of expected instructions, vector table.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    ifu_fetch #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
`ifdef IFU_MISALIGN_CHK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .inst_ready    (inst_ready),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;
    typedef struct { logic gnt; logic ready; logic exp_req; logic exp_valid; logic [31:0] exp_pc; } vec_t;

    pend_t       pending[$];
    exp_t        exp_q[$];
    logic [31:0] delivered[$];
    vec_t        vecs[11];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mdl_pc = RESET_PC;
    logic        mdl_active = 1'b0;
    logic        mdl_mis = 1'b0;
    logic        mem_hold = 1'b0;
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_inst;
    logic [31:0] s_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, advance the model, drive memory response after posedge.
    task automatic tick();
        logic  mreq;
        pend_t p;
        exp_t  e;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_pc    = inst_pc;
        mreq = rst_n && mdl_active && !redirect_valid && !mdl_mis && (pending.size() < MAXO)
               && (pending.size() + exp_q.size() < DEPTH);
        check("imem_req", 32'(s_req), 32'(mreq));
        check("inst_valid", 32'(s_valid), 32'(exp_q.size() != 0));
        if (!s_valid) begin
            check("inst_idle", s_inst, 32'h0);
            check("inst_pc_idle", s_pc, 32'h0);
        end
`ifdef IFU_MISALIGN_CHK_EN
        check("fetch_misalign", 32'(fetch_misalign), 32'(mdl_mis));
`endif
        if (imem_rvalid && pending.size() > 0) begin
            p = pending.pop_front();
            if (!p.stale && !redirect_valid) begin
                e.data = p.addr ^ 32'hA5A5_0000;
                e.pc   = p.addr;
                exp_q.push_back(e);
            end
        end
        if (s_valid && inst_ready && !redirect_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_inst", s_inst, e.data);
            check("sb_inst_pc", s_pc, e.pc);
            delivered.push_back(s_pc);
        end
        if (s_req && imem_gnt) begin
            check("imem_addr", s_addr, mdl_pc);
            p.addr  = mdl_pc;
            p.stale = 1'b0;
            pending.push_back(p);
            mdl_pc = mdl_pc + 32'd4;
        end
        if (redirect_valid) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            exp_q.delete();
            delivered.delete();
`ifdef IFU_MISALIGN_CHK_EN
            mdl_pc  = redirect_pc;
            mdl_mis = |redirect_pc[1:0];
`else
            mdl_pc  = {redirect_pc[31:2], 2'b00};
`endif
        end
        @(posedge clk);
        #1;
        mdl_active  = rst_n;
        imem_rvalid = (pending.size() > 0) && !mem_hold && rst_n;
        imem_rdata  = imem_rvalid ? (pending[0].addr ^ 32'hA5A5_0000) : 32'h0;
    endtask

    task automatic drain();
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        mem_hold   = 1'b0;
        for (int i = 0; i < 20 && (pending.size() + exp_q.size()) > 0; i++) tick();
        check("drain_empty", 32'(pending.size() + exp_q.size()), 32'h0);
    endtask

    task automatic run_until_delivered(input int n, input int budget);
        for (int i = 0; i < budget && delivered.size() < n; i++) tick();
        check("delivered_count", 32'(delivered.size() >= n), 32'h1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   fg;
        int   fv;
        logic [31:0] held;
        // gnt, ready, exp_req, exp_valid, exp_inst_pc (cycle 0 = first cycle after reset release)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC};

        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;

        // Fill with ready low, then release.
        for (int i = 0; i < 11; i++) begin
            imem_gnt   = vecs[i].gnt;
            inst_ready = vecs[i].ready;
            tick();
            check($sformatf("tbl%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
            check($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("tbl%0d_pc", i), s_pc, vecs[i].exp_pc);
        end

        // Streaming.
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        drain();

        // Grant stall: address held.
        tick();
        check("stall_req0", 32'(s_req), 32'h1);
        held = s_addr;
        for (int i = 1; i < 3; i++) begin
            tick();
            check("stall_req", 32'(s_req), 32'h1);
            check("stall_addr", s_addr, held);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        tick();
        check("post_stall_addr", s_addr, held + 32'd4);
        drain();

        // Redirect with two outstanding.
        mem_hold   = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 10 && pending.size() < 2; i++) tick();
        check("two_outstanding", 32'(pending.size()), 32'h2);
        do_redirect(32'h100);
        mem_hold = 1'b0;
        tick();
        check("redir_flush_valid", 32'(s_valid), 32'h0);
        run_until_delivered(2, 40);
        if (delivered.size() >= 2) begin
            check("redir_first_pc", delivered[0], 32'h100);
            check("redir_second_pc", delivered[1], 32'h104);
        end
        drain();

        // Back-to-back redirects: last wins.
        imem_gnt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        do_redirect(32'h400);
        run_until_delivered(1, 40);
        if (delivered.size() >= 1) check("b2b_first_pc", delivered[0], 32'h400);
        drain();

`ifdef IFU_MISALIGN_CHK_EN
        imem_gnt = 1'b1;
        do_redirect(32'h102);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mis_req", 32'(s_req), 32'h0);
            check("mis_flag", 32'(fetch_misalign), 32'h1);
        end
        do_redirect(32'h200);
        tick();
        check("mis_clear", 32'(fetch_misalign), 32'h0);
        run_until_delivered(1, 40);
        if (delivered.size() >= 1) check("mis_first_pc", delivered[0], 32'h200);
        drain();
`else
        imem_gnt = 1'b1;
        do_redirect(32'h203);
        run_until_delivered(1, 40);
        if (delivered.size() >= 1) check("unaligned_pc", delivered[0], 32'h200);
        drain();
`endif

        // Asynchronous reset mid-stream with a full buffer.
        imem_gnt   = 1'b1;
        inst_ready = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() < 2; i++) tick();
        check("fifo_full", 32'(exp_q.size()), 32'h2);
        #2;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        pending.delete();
        exp_q.delete();
        delivered.delete();
        mdl_pc     = RESET_PC;
        mdl_mis    = 1'b0;
        mdl_active = 1'b0;
        tick();
        tick();
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        fg = -1;
        fv = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fg < 0 && s_req && imem_gnt) begin
                fg = i;
                check("post_rst_addr", s_addr, RESET_PC);
            end
            if (fv < 0 && s_valid) fv = i;
        end
        check("first_latency", 32'(fv - fg), 32'h2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
